// File: rtl/kiosk_arbiter.sv
// Two-kiosk front end for a single vending core: round-robin grant, digit and
// payment forwarding, result capture, watchdog timeout and restock handling.
module kiosk_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic [2:0] CODE0,
  input  logic [2:0] CODE1,
  input  logic       PAY0,
  input  logic       PAY1,
  input  logic       RELOAD_REQ,
  input  logic       CORE_VEND,
  input  logic       CORE_INVALID_SEL,
  input  logic       CORE_FAILED_TRAN,
  input  logic [2:0] CORE_COST,
  output logic       CORE_CARD_IN,
  output logic       CORE_KEY_PRESS,
  output logic       CORE_VALID_TRAN,
  output logic       CORE_RELOAD,
  output logic [2:0] CORE_ITEM_CODE,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [1:0] STATUS,
  output logic [2:0] COST_OUT,
  output logic       BUSY
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RELOAD   = 3'd1;
  localparam logic [2:0] S_CARD     = 3'd2;
  localparam logic [2:0] S_DIGIT1   = 3'd3;
  localparam logic [2:0] S_DIGIT2   = 3'd4;
  localparam logic [2:0] S_WAIT_RES = 3'd5;
  localparam logic [2:0] S_RELEASE  = 3'd6;

  localparam logic [1:0] ST_VENDED  = 2'b00;
  localparam logic [1:0] ST_INVALID = 2'b01;
  localparam logic [1:0] ST_FAILED  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  logic [2:0] state, state_nx;
  logic       owner, owner_nx;
  logic       last_served;
  logic       reload_pend;
  logic [3:0] wdog;
  logic [1:0] status_r, status_nx;
  logic [2:0] cost_r;
  logic       fwd_key, fwd_pay;

  logic       own_req, own_key, own_pay;
  logic [2:0] own_code;
  logic       core_flag;
  logic [1:0] flag_status;
  logic       in_session;

  assign own_req  = owner ? REQ1  : REQ0;
  assign own_key  = owner ? KEY1  : KEY0;
  assign own_pay  = owner ? PAY1  : PAY0;
  assign own_code = owner ? CODE1 : CODE0;

  assign core_flag   = CORE_INVALID_SEL | CORE_FAILED_TRAN | CORE_VEND;
  assign flag_status = CORE_INVALID_SEL ? ST_INVALID :
                       CORE_FAILED_TRAN ? ST_FAILED  : ST_VENDED;
  assign in_session  = (state == S_CARD) || (state == S_DIGIT1) ||
                       (state == S_DIGIT2) || (state == S_WAIT_RES);

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_nx  = state;
    owner_nx  = owner;
    status_nx = status_r;
    fwd_key   = 1'b0;
    fwd_pay   = 1'b0;
    if (state == S_IDLE) begin
      if (reload_pend) begin
        state_nx = S_RELOAD;
      end else if (REQ0 || REQ1) begin
        state_nx = S_CARD;
        owner_nx = (REQ0 && REQ1) ? ~last_served : REQ1;
      end
    end else if (state == S_RELOAD || state == S_RELEASE) begin
      state_nx = S_IDLE;
    end else if (in_session) begin
      // A core result beats a card pull in the same cycle; the watchdog is last.
      if (core_flag) begin
        state_nx  = S_RELEASE;
        status_nx = flag_status;
      end else if (!own_req) begin
        state_nx  = S_RELEASE;
        status_nx = ST_TIMEOUT;
      end else if (state != S_CARD && wdog == 4'd15) begin
        state_nx  = S_RELEASE;
        status_nx = ST_TIMEOUT;
      end else begin
        case (state)
          S_CARD:   state_nx = S_DIGIT1;
          S_DIGIT1: if (own_key) begin fwd_key = 1'b1; state_nx = S_DIGIT2; end
          S_DIGIT2: if (own_key) begin fwd_key = 1'b1; state_nx = S_WAIT_RES; end
          default:  fwd_pay = own_pay;
        endcase
      end
    end else begin
      state_nx = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= S_IDLE;
      owner           <= 1'b0;
      last_served     <= 1'b1;
      reload_pend     <= 1'b0;
      wdog            <= 4'd0;
      status_r        <= ST_VENDED;
      cost_r          <= 3'd0;
      CORE_CARD_IN    <= 1'b0;
      CORE_KEY_PRESS  <= 1'b0;
      CORE_VALID_TRAN <= 1'b0;
      CORE_RELOAD     <= 1'b0;
      CORE_ITEM_CODE  <= 3'd0;
      GNT0            <= 1'b0;
      GNT1            <= 1'b0;
      DONE0           <= 1'b0;
      DONE1           <= 1'b0;
      STATUS          <= 2'b00;
      COST_OUT        <= 3'd0;
      BUSY            <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      status_r    <= status_nx;
      reload_pend <= (reload_pend && state != S_RELOAD) || RELOAD_REQ;

      if (state_nx != state || fwd_key || fwd_pay) wdog <= 4'd0;
      else if (wdog != 4'd15)                      wdog <= wdog + 4'd1;

      CORE_CARD_IN    <= (state == S_CARD);
      CORE_KEY_PRESS  <= fwd_key;
      CORE_VALID_TRAN <= fwd_pay;
      CORE_RELOAD     <= (state == S_RELOAD);
      if (fwd_key) CORE_ITEM_CODE <= own_code;

      if (state == S_IDLE && state_nx == S_CARD) cost_r <= 3'd0;
      else if (fwd_key && state == S_DIGIT2)     cost_r <= CORE_COST;

      if (state == S_CARD) begin
        GNT0 <= ~owner;
        GNT1 <= owner;
      end else if (state == S_RELEASE) begin
        GNT0 <= 1'b0;
        GNT1 <= 1'b0;
      end

      DONE0 <= (state == S_RELEASE) && !owner;
      DONE1 <= (state == S_RELEASE) && owner;
      if (state == S_RELEASE) begin
        STATUS      <= status_r;
        COST_OUT    <= cost_r;
        last_served <= owner;
      end

      BUSY <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_kiosk_arbiter.sv
// Self-checking bench for kiosk_arbiter: table-driven sessions, hand-written
// corner cases and randomized sessions against a transaction-level model.
module tb_kiosk_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 0, REQ1 = 0, KEY0 = 0, KEY1 = 0, PAY0 = 0, PAY1 = 0;
  logic [2:0] CODE0 = 0, CODE1 = 0, CORE_COST = 0;
  logic       RELOAD_REQ = 0, CORE_VEND = 0, CORE_INVALID_SEL = 0, CORE_FAILED_TRAN = 0;
  logic       CORE_CARD_IN, CORE_KEY_PRESS, CORE_VALID_TRAN, CORE_RELOAD;
  logic [2:0] CORE_ITEM_CODE, COST_OUT;
  logic       GNT0, GNT1, DONE0, DONE1, BUSY;
  logic [1:0] STATUS;

  int n_checks = 0;
  int n_fail   = 0;
  int last_model = 1;  // kiosk served most recently, as the model sees it

  kiosk_arbiter dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .KEY0(KEY0), .KEY1(KEY1),
    .CODE0(CODE0), .CODE1(CODE1), .PAY0(PAY0), .PAY1(PAY1), .RELOAD_REQ(RELOAD_REQ),
    .CORE_VEND(CORE_VEND), .CORE_INVALID_SEL(CORE_INVALID_SEL),
    .CORE_FAILED_TRAN(CORE_FAILED_TRAN), .CORE_COST(CORE_COST),
    .CORE_CARD_IN(CORE_CARD_IN), .CORE_KEY_PRESS(CORE_KEY_PRESS),
    .CORE_VALID_TRAN(CORE_VALID_TRAN), .CORE_RELOAD(CORE_RELOAD),
    .CORE_ITEM_CODE(CORE_ITEM_CODE), .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0),
    .DONE1(DONE1), .STATUS(STATUS), .COST_OUT(COST_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       r0, r1;
    logic [2:0] c1, c2, cost;
    logic [2:0] flags;  // {INVALID_SEL, FAILED_TRAN, VEND}
    int         exp_gnt;
    int         exp_st;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Invariants on every cycle out of reset.
  always @(negedge CLK) begin
    if (RESET) begin
      check("gnt_exclusive", int'(GNT0 && GNT1), 0);
      check("strobe_exclusive",
            int'($countones({CORE_CARD_IN, CORE_KEY_PRESS, CORE_VALID_TRAN, CORE_RELOAD}) > 1), 0);
    end
  end

  // Round-robin rule: on a tie the kiosk not served last wins.
  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return (last_model == 0) ? 1 : 0;
    return r0 ? 0 : 1;
  endfunction

  function automatic int status_of(input logic [2:0] f);
    if (f[2]) return 1;
    if (f[1]) return 2;
    return 0;
  endfunction

  task automatic wait_grant(output int who);
    bit got;
    got = 1'b0;
    who = -1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = GNT0 || GNT1;
    end
    check("grant_seen", int'(got), 1);
    if (got) who = GNT1 ? 1 : 0;
  endtask

  task automatic press(input int k, input logic [2:0] code);
    if (k == 1) begin KEY1 = 1; CODE1 = code; end
    else        begin KEY0 = 1; CODE0 = code; end
    step();
    KEY0 = 0; KEY1 = 0;
    check("key_press", CORE_KEY_PRESS, 1);
    check("item_code", CORE_ITEM_CODE, code);
  endtask

  // Idle cycles, optionally with the other kiosk keying and paying.
  task automatic pause(input int n, input bit noise, input int k);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        if (k == 0) begin KEY1 = 1; CODE1 = 3'($urandom); PAY1 = 1; end
        else        begin KEY0 = 1; CODE0 = 3'($urandom); PAY0 = 1; end
      end
      step();
      KEY0 = 0; KEY1 = 0; PAY0 = 0; PAY1 = 0;
      check("foreign_key", CORE_KEY_PRESS, 0);
      check("foreign_pay", CORE_VALID_TRAN, 0);
    end
  endtask

  task automatic session(input logic r0, input logic r1, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [2:0] cost,
                         input logic [2:0] flags, input int exp_g, input int exp_st,
                         input int gap, input bit noise);
    int who;
    REQ0 = r0; REQ1 = r1;
    wait_grant(who);
    check("grant_who", who, exp_g);
    if (who < 0) begin
      REQ0 = 0; REQ1 = 0;
      repeat (20) step();
      return;
    end
    check("card_in", CORE_CARD_IN, 1);
    check("busy_in_session", BUSY, 1);
    pause(gap, noise, exp_g);
    press(exp_g, c1);
    pause(gap, noise, exp_g);
    CORE_COST = cost;
    press(exp_g, c2);
    CORE_COST = ~cost;  // later values must not leak into COST_OUT
    pause(gap, noise, exp_g);
    if (exp_g == 1) PAY1 = 1; else PAY0 = 1;
    step();
    PAY0 = 0; PAY1 = 0;
    check("valid_tran", CORE_VALID_TRAN, 1);
    pause(gap, noise, exp_g);
    {CORE_INVALID_SEL, CORE_FAILED_TRAN, CORE_VEND} = flags;
    step();
    {CORE_INVALID_SEL, CORE_FAILED_TRAN, CORE_VEND} = 3'b000;
    REQ0 = 0; REQ1 = 0;
    step();
    check("done_owner", (exp_g == 1) ? DONE1 : DONE0, 1);
    check("done_other", (exp_g == 1) ? DONE0 : DONE1, 0);
    check("status", STATUS, exp_st);
    check("cost_out", COST_OUT, cost);
    check("gnt_dropped", int'(GNT0 || GNT1), 0);
    check("busy_idle", BUSY, 0);
    step();
    check("done_one_cycle", int'(DONE0 || DONE1), 0);
    check("status_held", STATUS, exp_st);
    last_model = exp_g;
  endtask

  initial begin
    int who, cnt, n_rel;
    logic [1:0] r;
    logic [2:0] f;

    tbl[0] = '{1, 1, 3'd1, 3'd4, 3'd5, 3'b001, 0, 0};
    tbl[1] = '{1, 1, 3'd6, 3'd2, 3'd7, 3'b001, 1, 0};
    tbl[2] = '{0, 1, 3'd3, 3'd3, 3'd2, 3'b101, 1, 1};
    tbl[3] = '{1, 0, 3'd7, 3'd0, 3'd1, 3'b010, 0, 2};
    tbl[4] = '{1, 1, 3'd5, 3'd5, 3'd4, 3'b011, 1, 2};
    tbl[5] = '{1, 1, 3'd0, 3'd7, 3'd6, 3'b110, 0, 1};
    tbl[6] = '{1, 0, 3'd2, 3'd1, 3'd0, 3'b001, 0, 0};
    tbl[7] = '{1, 1, 3'd4, 3'd6, 3'd3, 3'b100, 1, 1};

    #3 RESET = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs",
          int'({CORE_CARD_IN, CORE_KEY_PRESS, CORE_VALID_TRAN, CORE_RELOAD, CORE_ITEM_CODE,
                GNT0, GNT1, DONE0, DONE1, STATUS, COST_OUT, BUSY}), 0);
    RESET = 1;

    for (int i = 0; i < 8; i++)
      session(tbl[i].r0, tbl[i].r1, tbl[i].c1, tbl[i].c2, tbl[i].cost, tbl[i].flags,
              tbl[i].exp_gnt, tbl[i].exp_st, 1, 1'b1);

    // Two merged restock requests, a card waiting behind them, then a full vend.
    RELOAD_REQ = 1;
    step();
    REQ0 = 1;
    step();
    RELOAD_REQ = 0;
    n_rel = 0;
    step();
    n_rel += int'(CORE_RELOAD);
    check("reload_before_grant", int'(CORE_RELOAD && !GNT0), 1);
    step();
    n_rel += int'(CORE_RELOAD);
    check("reload_single_pulse", n_rel, 1);
    session(1, 0, 3'd1, 3'd4, 3'd5, 3'b001, 0, 0, 0, 1'b0);

    // Card pulled right after the grant.
    REQ1 = 1;
    wait_grant(who);
    check("pull_grant_who", who, 1);
    REQ1 = 0;
    step();
    step();
    check("pull_done", DONE1, 1);
    check("pull_status", STATUS, 3);
    step();
    last_model = 1;

    // One digit, then silence: the watchdog restarts on entry to the second-digit
    // phase and fires when it reads 15; release costs one more edge.
    REQ0 = 1;
    wait_grant(who);
    check("wd_grant_who", who, 0);
    press(0, 3'd3);
    cnt = 0;
    while (cnt < 40 && !DONE0) begin
      step();
      cnt++;
      if (cnt == 16) REQ0 = 0;
    end
    check("wd_latency", cnt, 17);
    check("wd_status", STATUS, 3);
    step();
    last_model = 0;

    // Reset asserted while waiting for the core result.
    REQ0 = 1;
    wait_grant(who);
    check("rst_grant_who", who, 0);
    press(0, 3'd2);
    CORE_COST = 3'd6;
    press(0, 3'd5);
    PAY0 = 1;
    step();
    PAY0 = 0;
    check("rst_valid_tran", CORE_VALID_TRAN, 1);
    #2 RESET = 0;
    #1;
    check("rst_gnt_async", GNT0, 0);
    check("rst_busy_async", BUSY, 0);
    check("rst_done_async", DONE0, 0);
    check("rst_status_async", STATUS, 0);
    REQ0 = 0;
    step();
    step();
    RESET = 1;
    last_model = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(DONE0 || DONE1 || GNT0 || GNT1);
    end
    check("no_done_after_reset", cnt, 0);

    // Tie right after reset must go to kiosk0 again.
    session(1, 1, 3'd7, 3'd1, 3'd2, 3'b001, pick(1, 1), 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      f = 3'($urandom_range(1, 7));
      session(r[0], r[1], 3'($urandom), 3'($urandom), 3'($urandom), f,
              pick(r[0], r[1]), status_of(f), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
